// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit -- single-issue instruction fetch stage.
//
// Holds the PC and issues one fetch request per cycle to instruction memory.
// A transfer (imemReq & imemAck) captures {PC, word} into a one-entry output
// slot that feeds the IF/ID register. The slot is consumed on every edge
// where control[1] is low. If nothing new arrives on that edge, the slot
// turns into a zero NOP bubble.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   control[5:0]  in   bit0 fetch stall, bit1 IF/ID stall, bits 5:2 unused
//   branchFlag    in   one-cycle redirect request
//   branchTarget  in   redirect address
//   imemReq       out  fetch request (combinational)
//   imemAddr      out  fetch address (= PC register)
//   imemAck       in   memory ready
//   imemData      in   instruction word, valid in a transfer cycle
//   insFetchPC    out  slot PC
//   insFetchInst  out  slot instruction
module ins_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  control,
    input  logic        branchFlag,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] insFetchPC,
    output logic [31:0] insFetchInst
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_inst_q, slot_inst_d;
    logic        slot_vld_q, slot_vld_d;
    logic        xfer;

    logic unused_ctl;
    assign unused_ctl = ^control[5:2];

    // No request in the following cases:
    //   - A full slot cannot drain this cycle.
    //   - A redirect arrives while the delay slot is already held. If we
    //     fetched here, the wrong-path word would be captured.
    assign imemReq = !rst && !control[0] && !(slot_vld_q && control[1])
                     && !(branchFlag && slot_vld_q);
    assign xfer    = imemReq && imemAck;

    assign imemAddr     = pc_q;
    assign insFetchPC   = slot_pc_q;
    assign insFetchInst = slot_inst_q;

    always_comb begin
        pc_d        = pc_q;
        slot_pc_d   = slot_pc_q;
        slot_inst_d = slot_inst_q;
        slot_vld_d  = slot_vld_q;

        if (xfer) begin
            slot_pc_d   = pc_q;
            slot_inst_d = imemData;
            slot_vld_d  = 1'b1;
            pc_d        = pc_q + 32'd4;
        end else if (!control[1]) begin
            // Slot consumed with nothing behind it: present a bubble.
            slot_pc_d   = 32'h0;
            slot_inst_d = 32'h0;
            slot_vld_d  = 1'b0;
        end

        // The redirect wins over sequential advance. A word captured in the
        // same cycle is kept as the delay-slot instruction.
        if (branchFlag) begin
            pc_d = branchTarget;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            slot_pc_q   <= 32'h0;
            slot_inst_q <= 32'h0;
            slot_vld_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            slot_pc_q   <= slot_pc_d;
            slot_inst_q <= slot_inst_d;
            slot_vld_q  <= slot_vld_d;
        end
    end

endmodule
